axi_lite_slave_regs: RTL and testbench

//  AXI4-Lite responder (slave) holding the matrix accelerator's control/status register bank.

---
 rtl/axi_lite_slave_regs.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// axi_lite_slave_regs: AXI4-Lite control/status register bank for the matrix accelerator.
// Define AXIL_IRQ_EN to add the IRQ_EN register and the registered irq_o output.
module axi_lite_slave_regs #(
    parameter int          NUM_ARGS = 4,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                   ACLK,
    input  logic                   ARST,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [31:0]            AWADDR,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic [31:0]            WDATA,
    input  logic [3:0]             WSTRB,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [1:0]             BRESP,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [31:0]            ARADDR,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [31:0]            RDATA,
    output logic [1:0]             RRESP,
    output logic                   start_o,
    output logic [32*NUM_ARGS-1:0] args_o,
    input  logic                   busy_i,
    input  logic                   done_i
`ifdef AXIL_IRQ_EN
    ,
    output logic                   irq_o
`endif
);

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_COMMIT,
        W_RESP
    } wstate_t;

    localparam logic [5:0] IDX_CTRL     = 6'd0;
    localparam logic [5:0] IDX_STATUS   = 6'd1;
    localparam logic [5:0] IDX_ARG_LAST = 6'(NUM_ARGS + 1);
`ifdef AXIL_IRQ_EN
    localparam logic [5:0] IDX_IRQ      = 6'(NUM_ARGS + 2);
`endif
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    wstate_t                    r_wState;
    logic                       r_awReady;
    logic                       r_wReady;
    logic                       r_bValid;
    logic [1:0]                 r_bResp;
    logic [5:0]                 r_wIdx;
    logic [31:0]                r_wData;
    logic [3:0]                 r_wStrb;

    logic                       r_arReady;
    logic                       r_rValid;
    logic [31:0]                r_rData;
    logic [1:0]                 r_rResp;

    logic [NUM_ARGS-1:0][31:0]  r_args;
    logic                       r_done;
    logic                       r_start;
`ifdef AXIL_IRQ_EN
    logic                       r_irqEn;
    logic                       r_irq;
`endif

    logic [5:0]                 w_rIdx;
    logic                       w_rInRange;
    logic                       w_wInRange;
    logic                       w_commit;
    logic [31:0]                w_rdData;
    logic                       w_unused;

    function automatic logic idxInRange(input logic [5:0] idx);
`ifdef AXIL_IRQ_EN
        return (idx <= IDX_ARG_LAST) || (idx == IDX_IRQ);
`else
        return idx <= IDX_ARG_LAST;
`endif
    endfunction

    // Only the word index ADDR[7:2] decodes; the remaining address bits are don't-care.
    assign w_rIdx     = ARADDR[7:2];
    assign w_unused   = ^{AWADDR[31:8], AWADDR[1:0], ARADDR[31:8], ARADDR[1:0]};
    assign w_rInRange = idxInRange(w_rIdx);
    assign w_wInRange = idxInRange(r_wIdx);
    assign w_commit   = (r_wState == W_COMMIT);

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_wState  <= W_IDLE;
            r_awReady <= 1'b1;
            r_wReady  <= 1'b1;
            r_bValid  <= 1'b0;
            r_bResp   <= RESP_OKAY;
            r_wIdx    <= '0;
            r_wData   <= '0;
            r_wStrb   <= '0;
        end else begin
            case (r_wState)
                W_IDLE: begin
                    if (AWVALID) begin
                        r_wIdx <= AWADDR[7:2];
                    end
                    if (WVALID) begin
                        r_wData <= WDATA;
                        r_wStrb <= WSTRB;
                    end
                    if (AWVALID && WVALID) begin
                        r_awReady <= 1'b0;
                        r_wReady  <= 1'b0;
                        r_wState  <= W_COMMIT;
                    end else if (AWVALID) begin
                        r_awReady <= 1'b0;
                        r_wState  <= W_HAVE_AW;
                    end else if (WVALID) begin
                        r_wReady <= 1'b0;
                        r_wState <= W_HAVE_W;
                    end
                end
                W_HAVE_AW: begin
                    if (WVALID) begin
                        r_wData  <= WDATA;
                        r_wStrb  <= WSTRB;
                        r_wReady <= 1'b0;
                        r_wState <= W_COMMIT;
                    end
                end
                W_HAVE_W: begin
                    if (AWVALID) begin
                        r_wIdx    <= AWADDR[7:2];
                        r_awReady <= 1'b0;
                        r_wState  <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    r_bValid <= 1'b1;
                    r_bResp  <= w_wInRange ? RESP_OKAY : RESP_SLVERR;
                    r_wState <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        r_bValid  <= 1'b0;
                        r_awReady <= 1'b1;
                        r_wReady  <= 1'b1;
                        r_wState  <= W_IDLE;
                    end
                end
                default: r_wState <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rdData = 32'd0;
        if (w_rIdx == IDX_STATUS) begin
            w_rdData = {30'd0, r_done, busy_i};
        end
        for (int k = 0; k < NUM_ARGS; k++) begin
            if (w_rIdx == 6'(k + 2)) begin
                w_rdData = r_args[k];
            end
        end
`ifdef AXIL_IRQ_EN
        if (w_rIdx == IDX_IRQ) begin
            w_rdData = {31'd0, r_irqEn};
        end
`endif
        if (!w_rInRange) begin
            w_rdData = ERR_DATA;
        end
    end

    // Read data is captured from the pre-edge register state, so a read that
    // lands on a commit edge sees the old value.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_arReady <= 1'b1;
            r_rValid  <= 1'b0;
            r_rData   <= '0;
            r_rResp   <= RESP_OKAY;
        end else if (r_rValid) begin
            if (RREADY) begin
                r_rValid  <= 1'b0;
                r_arReady <= 1'b1;
            end
        end else if (ARVALID) begin
            r_rValid  <= 1'b1;
            r_arReady <= 1'b0;
            r_rData   <= w_rdData;
            r_rResp   <= w_rInRange ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // DONE set is evaluated last so a coincident done_i beats the W1C clear.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_args  <= '0;
            r_done  <= 1'b0;
            r_start <= 1'b0;
`ifdef AXIL_IRQ_EN
            r_irqEn <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            if (w_commit && w_wInRange) begin
                if (r_wIdx == IDX_CTRL) begin
                    r_start <= r_wStrb[0] & r_wData[0];
                end
                if ((r_wIdx == IDX_STATUS) && r_wStrb[0] && r_wData[1]) begin
                    r_done <= 1'b0;
                end
                for (int k = 0; k < NUM_ARGS; k++) begin
                    if (r_wIdx == 6'(k + 2)) begin
                        for (int b = 0; b < 4; b++) begin
                            if (r_wStrb[b]) begin
                                r_args[k][8*b +: 8] <= r_wData[8*b +: 8];
                            end
                        end
                    end
                end
`ifdef AXIL_IRQ_EN
                if ((r_wIdx == IDX_IRQ) && r_wStrb[0]) begin
                    r_irqEn <= r_wData[0];
                end
`endif
            end
            if (done_i) begin
                r_done <= 1'b1;
            end
        end
    end

`ifdef AXIL_IRQ_EN
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_done & r_irqEn;
        end
    end

    assign irq_o = r_irq;
`endif

    assign AWREADY = r_awReady;
    assign WREADY  = r_wReady;
    assign BVALID  = r_bValid;
    assign BRESP   = r_bResp;
    assign ARREADY = r_arReady;
    assign RVALID  = r_rValid;
    assign RDATA   = r_rData;
    assign RRESP   = r_rResp;
    assign start_o = r_start;
    assign args_o  = r_args;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb_axi_lite_slave_regs: table vectors, directed corner sequences and random traffic
// checked against a register-map reference model. Honours AXIL_IRQ_EN like the design.
module tb_axi_lite_slave_regs;

    localparam int          NUM_ARGS = 4;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
`ifdef AXIL_IRQ_EN
    localparam bit          HAS_IRQ  = 1'b1;
`else
    localparam bit          HAS_IRQ  = 1'b0;
`endif

    logic                   ACLK;
    logic                   ARST;
    logic                   AWVALID;
    logic                   AWREADY;
    logic [31:0]            AWADDR;
    logic                   WVALID;
    logic                   WREADY;
    logic [31:0]            WDATA;
    logic [3:0]             WSTRB;
    logic                   BVALID;
    logic                   BREADY;
    logic [1:0]             BRESP;
    logic                   ARVALID;
    logic                   ARREADY;
    logic [31:0]            ARADDR;
    logic                   RVALID;
    logic                   RREADY;
    logic [31:0]            RDATA;
    logic [1:0]             RRESP;
    logic                   start_o;
    logic [32*NUM_ARGS-1:0] args_o;
    logic                   busy_i;
    logic                   done_i;
`ifdef AXIL_IRQ_EN
    logic                   irq_o;
`endif

    axi_lite_slave_regs #(
        .NUM_ARGS (NUM_ARGS),
        .ERR_DATA (ERR_DATA)
    ) dut (
        .ACLK    (ACLK),
        .ARST    (ARST),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .AWADDR  (AWADDR),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .ARADDR  (ARADDR),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .start_o (start_o),
        .args_o  (args_o),
        .busy_i  (busy_i),
        .done_i  (done_i)
`ifdef AXIL_IRQ_EN
        ,
        .irq_o   (irq_o)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int testsRun    = 0;
    int testsFailed = 0;
    int startCount  = 0;

    // Count start pulses so their number can be checked independent of timing.
    always @(posedge ACLK) begin
        if (start_o === 1'b1) startCount++;
    end

    // Reference model: the register map as plain variables.
    logic [31:0] refArgs [NUM_ARGS];
    logic        refDone;
    logic        refIrqEn;

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] expData;
        logic [1:0]  expResp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int idxOf(input logic [31:0] addr);
        return int'(addr[7:2]);
    endfunction

    function automatic bit refInRange(input logic [31:0] addr);
        int idx = idxOf(addr);
        return (idx <= NUM_ARGS + 1) || (HAS_IRQ && idx == NUM_ARGS + 2);
    endfunction

    task automatic refReset();
        foreach (refArgs[k]) refArgs[k] = 32'd0;
        refDone  = 1'b0;
        refIrqEn = 1'b0;
    endtask

    task automatic refWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = idxOf(addr);
        if (!refInRange(addr)) return;
        if (idx == 1) begin
            if (strb[0] && data[1]) refDone = 1'b0;
        end else if (idx >= 2 && idx <= NUM_ARGS + 1) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) refArgs[idx-2][8*b +: 8] = data[8*b +: 8];
        end else if (idx == NUM_ARGS + 2) begin
            if (strb[0]) refIrqEn = data[0];
        end
    endtask

    task automatic refRead(input logic [31:0] addr, input logic busy,
                           output logic [31:0] data, output logic [1:0] resp);
        int idx = idxOf(addr);
        data = 32'd0;
        resp = 2'b00;
        if (!refInRange(addr)) begin
            data = ERR_DATA;
            resp = 2'b10;
        end else if (idx == 1) begin
            data = {30'd0, refDone, busy};
        end else if (idx >= 2 && idx <= NUM_ARGS + 1) begin
            data = refArgs[idx-2];
        end else if (idx == NUM_ARGS + 2) begin
            data = {31'd0, refIrqEn};
        end
    endtask

    task automatic doReset();
        ARST = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        ARST = 1'b0;
        refReset();
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        int   n = 0;
        logic awHs;
        logic wHs;
        AWADDR  = addr;
        WDATA   = data;
        WSTRB   = strb;
        AWVALID = 1'b1;
        WVALID  = 1'b1;
        while ((AWVALID || WVALID) && n < 20) begin
            awHs = AWVALID && AWREADY;
            wHs  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (awHs) AWVALID = 1'b0;
            if (wHs)  WVALID  = 1'b0;
            n++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        BREADY  = 1'b1;
        n = 0;
        while (BVALID !== 1'b1 && n < 20) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        checkOutput("wr_bvalid_seen", 32'(BVALID), 32'd1);
        resp = BRESP;
        @(posedge ACLK);
        #1;
        BREADY = 1'b0;
    endtask

    task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        ARADDR  = addr;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 20) begin
            @(posedge ACLK);
            #1;
            n++;
        end
        @(posedge ACLK);
        #1;
        ARVALID = 1'b0;
        checkOutput("rd_rvalid_next_cycle", 32'(RVALID), 32'd1);
        data   = RDATA;
        resp   = RRESP;
        RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        RREADY = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [31:0] d;
        logic [1:0]  r;
        if (v.isWrite) begin
            axiWrite(v.addr, v.data, v.strb, r);
            refWrite(v.addr, v.data, v.strb);
            checkOutput({v.name, "_bresp"}, 32'(r), 32'(v.expResp));
        end else begin
            axiRead(v.addr, d, r);
            checkOutput({v.name, "_rdata"}, d, v.expData);
            checkOutput({v.name, "_rresp"}, 32'(r), 32'(v.expResp));
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests run %0d", testsRun);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          cntBefore;

        ARST = 1'b0; AWVALID = 1'b0; AWADDR = '0; WVALID = 1'b0; WDATA = '0; WSTRB = '0;
        BREADY = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0; busy_i = 1'b0; done_i = 1'b0;
        refReset();
        doReset();

        // Reset values.
        checkOutput("rst_awready", 32'(AWREADY), 32'd1);
        checkOutput("rst_wready",  32'(WREADY),  32'd1);
        checkOutput("rst_arready", 32'(ARREADY), 32'd1);
        checkOutput("rst_bvalid",  32'(BVALID),  32'd0);
        checkOutput("rst_rvalid",  32'(RVALID),  32'd0);
        checkOutput("rst_bresp",   32'(BRESP),   32'd0);
        checkOutput("rst_rresp",   32'(RRESP),   32'd0);
        checkOutput("rst_rdata",   RDATA,        32'd0);
        checkOutput("rst_start",   32'(start_o), 32'd0);
        for (int k = 0; k < NUM_ARGS; k++) checkOutput("rst_args", args_o[32*k +: 32], 32'd0);

        // AW and W together: BVALID two cycles after the handshake cycle.
        @(posedge ACLK); #1;
        AWADDR = 32'h08; WDATA = 32'h1234_5678; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        checkOutput("t1_bvalid_n1", 32'(BVALID), 32'd0);
        checkOutput("t1_awready_n1", 32'(AWREADY), 32'd0);
        @(posedge ACLK); #1;
        checkOutput("t1_bvalid_n2", 32'(BVALID), 32'd1);
        checkOutput("t1_bresp", 32'(BRESP), 32'd0);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        checkOutput("t1_bvalid_drop", 32'(BVALID), 32'd0);
        checkOutput("t1_awready_back", 32'(AWREADY), 32'd1);
        refWrite(32'h08, 32'h1234_5678, 4'hF);
        axiRead(32'h08, d, r);
        checkOutput("t1_arg0_read", d, 32'h1234_5678);

        // W three cycles ahead of AW, single byte lane.
        @(posedge ACLK); #1;
        WDATA = 32'hFFFF_FFFF; WSTRB = 4'b0010; WVALID = 1'b1;
        @(posedge ACLK); #1;
        WVALID = 1'b0; WDATA = 32'd0; WSTRB = 4'd0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t2_wready_low", 32'(WREADY), 32'd0);
            checkOutput("t2_awready_high", 32'(AWREADY), 32'd1);
            @(posedge ACLK); #1;
        end
        AWADDR = 32'h0C; AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("t2_bvalid", 32'(BVALID), 32'd1);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        refWrite(32'h0C, 32'hFFFF_FFFF, 4'b0010);
        axiRead(32'h0C, d, r);
        checkOutput("t2_arg1_read", d, 32'h0000_FF00);

        // CTRL start pulse with B held off for five cycles.
        cntBefore = startCount;
        @(posedge ACLK); #1;
        AWADDR = 32'h00; WDATA = 32'h1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        checkOutput("t3_start_pre", 32'(start_o), 32'd0);
        @(posedge ACLK); #1;
        checkOutput("t3_start_pulse", 32'(start_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("t3_bvalid_hold", 32'(BVALID), 32'd1);
            checkOutput("t3_bresp_hold", 32'(BRESP), 32'd0);
            @(posedge ACLK); #1;
            checkOutput("t3_start_single", 32'(start_o), 32'd0);
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        checkOutput("t3_bvalid_drop", 32'(BVALID), 32'd0);
        checkOutput("t3_start_count", 32'(startCount - cntBefore), 32'd1);
        axiRead(32'h00, d, r);
        checkOutput("t3_ctrl_reads0", d, 32'd0);
        cntBefore = startCount;
        axiWrite(32'h00, 32'h1, 4'b1110, r);
        repeat (2) @(posedge ACLK);
        #1;
        checkOutput("t3_strb_suppress", 32'(startCount - cntBefore), 32'd0);

        // DONE sticky, busy passthrough, W1C, and set winning over clear.
        @(posedge ACLK); #1;
        done_i = 1'b1;
        @(posedge ACLK); #1;
        done_i = 1'b0;
        refDone = 1'b1;
        axiRead(32'h04, d, r);
        checkOutput("t4_done_set", d, 32'h2);
        busy_i = 1'b1;
        axiRead(32'h04, d, r);
        checkOutput("t4_busy_done", d, 32'h3);
        busy_i = 1'b0;
        axiWrite(32'h04, 32'h2, 4'hF, r);
        refWrite(32'h04, 32'h2, 4'hF);
        axiRead(32'h04, d, r);
        checkOutput("t4_done_cleared", d, 32'h0);
        @(posedge ACLK); #1;
        AWADDR = 32'h04; WDATA = 32'h2; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0; done_i = 1'b1;
        @(posedge ACLK); #1;
        done_i = 1'b0;
        checkOutput("t4_col_bvalid", 32'(BVALID), 32'd1);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        refWrite(32'h04, 32'h2, 4'hF);
        refDone = 1'b1;
        axiRead(32'h04, d, r);
        checkOutput("t4_set_wins", d, 32'h2);

        // Table vectors; state entering: ARG0=12345678, ARG1=0000FF00, DONE=1.
        vecs.push_back('{1'b0, 32'h08,  32'h0,         4'h0,    32'h1234_5678, 2'b00, "tbl_rd_arg0"});
        vecs.push_back('{1'b0, 32'h0C,  32'h0,         4'h0,    32'h0000_FF00, 2'b00, "tbl_rd_arg1"});
        vecs.push_back('{1'b1, 32'h0C,  32'h1122_3344, 4'b0101, 32'h0,         2'b00, "tbl_wr_arg1_b02"});
        vecs.push_back('{1'b0, 32'h0C,  32'h0,         4'h0,    32'h0022_FF44, 2'b00, "tbl_rd_arg1_mask"});
        vecs.push_back('{1'b1, 32'h14,  32'hA5A5_A5A5, 4'b1001, 32'h0,         2'b00, "tbl_wr_arg3_b03"});
        vecs.push_back('{1'b0, 32'h14,  32'h0,         4'h0,    32'hA500_00A5, 2'b00, "tbl_rd_arg3"});
        vecs.push_back('{1'b1, 32'h10,  32'hCAFE_F00D, 4'hF,    32'h0,         2'b00, "tbl_wr_arg2"});
        vecs.push_back('{1'b0, 32'h10,  32'h0,         4'h0,    32'hCAFE_F00D, 2'b00, "tbl_rd_arg2"});
        vecs.push_back('{1'b0, 32'h80,  32'h0,         4'h0,    ERR_DATA,      2'b10, "tbl_rd_oor80"});
        vecs.push_back('{1'b1, 32'h80,  32'hFFFF_FFFF, 4'hF,    32'h0,         2'b10, "tbl_wr_oor80"});
        vecs.push_back('{1'b0, 32'hFC,  32'h0,         4'h0,    ERR_DATA,      2'b10, "tbl_rd_oorFC"});
        vecs.push_back('{1'b0, 32'h0B,  32'h0,         4'h0,    32'h1234_5678, 2'b00, "tbl_rd_lowbits"});
        vecs.push_back('{1'b0, 32'h308, 32'h0,         4'h0,    32'h1234_5678, 2'b00, "tbl_rd_highbits"});
        vecs.push_back('{1'b0, 32'h04,  32'h0,         4'h0,    32'h2,         2'b00, "tbl_rd_status"});
        vecs.push_back('{1'b0, 32'h00,  32'h0,         4'h0,    32'h0,         2'b00, "tbl_rd_ctrl"});
        if (HAS_IRQ) begin
            vecs.push_back('{1'b0, 32'h18, 32'h0, 4'h0, 32'h0, 2'b00, "tbl_rd_irqen"});
            vecs.push_back('{1'b1, 32'h18, 32'h0, 4'hF, 32'h0, 2'b00, "tbl_wr_irqen"});
        end else begin
            vecs.push_back('{1'b0, 32'h18, 32'h0, 4'h0, ERR_DATA, 2'b10, "tbl_rd_idx6"});
            vecs.push_back('{1'b1, 32'h18, 32'h0, 4'hF, 32'h0,    2'b10, "tbl_wr_idx6"});
        end
        foreach (vecs[i]) applyStimulus(vecs[i]);
        for (int k = 0; k < NUM_ARGS; k++) checkOutput("tbl_args_o", args_o[32*k +: 32], refArgs[k]);

        // Reset while a write waits for W and a read response is pending.
        @(posedge ACLK); #1;
        ARADDR = 32'h08; ARVALID = 1'b1; RREADY = 1'b0;
        AWADDR = 32'h08; AWVALID = 1'b1; WDATA = 32'h5555_AAAA; WSTRB = 4'hF;
        @(posedge ACLK); #1;
        ARVALID = 1'b0; AWVALID = 1'b0;
        checkOutput("t6_rvalid_pending", 32'(RVALID), 32'd1);
        checkOutput("t6_awready_low", 32'(AWREADY), 32'd0);
        ARST = 1'b1; WVALID = 1'b1;
        @(posedge ACLK); #1;
        ARST = 1'b0; WVALID = 1'b0;
        refReset();
        checkOutput("t6_rvalid_drop", 32'(RVALID), 32'd0);
        checkOutput("t6_awready", 32'(AWREADY), 32'd1);
        checkOutput("t6_wready", 32'(WREADY), 32'd1);
        checkOutput("t6_arready", 32'(ARREADY), 32'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t6_no_bvalid", 32'(BVALID), 32'd0);
            @(posedge ACLK); #1;
        end
        axiRead(32'h08, d, r);
        checkOutput("t6_arg0_not_written", d, 32'd0);

`ifdef AXIL_IRQ_EN
        axiWrite(32'h18, 32'h1, 4'hF, r);
        refWrite(32'h18, 32'h1, 4'hF);
        checkOutput("t6_irq_idle", 32'(irq_o), 32'd0);
        done_i = 1'b1;
        @(posedge ACLK); #1;
        done_i = 1'b0;
        refDone = 1'b1;
        checkOutput("t6_irq_delayed", 32'(irq_o), 32'd0);
        @(posedge ACLK); #1;
        checkOutput("t6_irq_set", 32'(irq_o), 32'd1);
`endif

        // Random traffic against the reference model.
        for (int t = 0; t < 200; t++) begin
            logic [31:0] rnd;
            logic [31:0] addr;
            logic [31:0] data;
            logic [31:0] expD;
            logic [1:0]  expR;
            logic [3:0]  strb;
            logic [5:0]  idx;
            rnd    = $urandom();
            idx    = 6'($urandom_range(0, NUM_ARGS + 3));
            addr   = {rnd[31:8], idx, rnd[1:0]};
            data   = $urandom();
            strb   = 4'($urandom_range(0, 15));
            busy_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                expR = refInRange(addr) ? 2'b00 : 2'b10;
                axiWrite(addr, data, strb, r);
                refWrite(addr, data, strb);
                checkOutput("rnd_bresp", 32'(r), 32'(expR));
            end else begin
                refRead(addr, busy_i, expD, expR);
                axiRead(addr, d, r);
                checkOutput("rnd_rdata", d, expD);
                checkOutput("rnd_rresp", 32'(r), 32'(expR));
            end
        end
        busy_i = 1'b0;
        for (int k = 0; k < NUM_ARGS; k++) checkOutput("rnd_args_o", args_o[32*k +: 32], refArgs[k]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
